crd_stream_sink: RTL and testbench

CRD_STREAM_SINK -- requirements
Module: crd_stream_sink

---
 rtl/sparse_stream_pkg.sv | 22 ++
 rtl/sink_mem.sv | 33 +++
 rtl/crd_stream_sink.sv | 93 +++++++++
 tb/tb_crd_stream_sink.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sparse_stream_pkg.sv
// Shared definitions for the sparse stream sink: control-token encoding,
// sink FSM states and the done-token decoder.
package sparse_stream_pkg;

  localparam int unsigned CTRL_BIT   = 16;
  localparam logic [16:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_t;

  // A done token is the control flag at bit width-1 plus the DONE_TOKEN
  // payload in the low bits; every other bit must be zero.
  function automatic logic is_done_token(input logic [63:0] w, input int unsigned width);
    logic [63:0] tok;
    tok = 64'(DONE_TOKEN[CTRL_BIT-1:0]) | (64'd1 << (width - 1));
    return w == tok;
  endfunction

endpackage

// File: rtl/sink_mem.sv
// Capture storage: one write port, one registered read port.
// Array contents are not reset; only the read register is.
module sink_mem #(
  parameter  int unsigned DATA_W = 17,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write captured words.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered readback, one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/crd_stream_sink.sv
// Stream sink: captures handshaked words into memory until TX_NUM done
// tokens have arrived, counting words, cycles and overflow attempts.
module crd_stream_sink
  import sparse_stream_pkg::*;
#(
  parameter  int unsigned DATA_W = 17,
  parameter  int unsigned DEPTH  = 64,
  parameter  int unsigned TX_NUM = 1,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned WCW    = AW + 1,
  localparam int unsigned TXW    = $clog2(TX_NUM) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  input  logic              stall,
  output logic              done,
  output logic [WCW-1:0]    word_count,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [63:0]       cycle_count,
  output logic              overflow
);

  state_t         r_state, w_state_nxt;
  logic [WCW-1:0] r_wc;
  logic [TXW-1:0] r_tx;
  logic [63:0]    r_cyc;
  logic           r_ovf;

  logic w_full, w_ready, w_xfer, w_done_tok, w_last_tok;

  assign w_full     = (r_wc == WCW'(DEPTH));
  assign w_done_tok = is_done_token(64'(data), DATA_W);
  // Reset is folded into ready so a word offered alongside rst never transfers.
  assign w_ready    = (r_state == RECV) && !stall && !w_full && !rst;
  assign w_xfer     = valid && w_ready;
  assign w_last_tok = w_xfer && w_done_tok && (r_tx == TXW'(TX_NUM - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: arm in IDLE, receive until the final done token, then hold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid) w_state_nxt = RECV;
      RECV:    if (w_last_tok) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word, token and cycle counters plus sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wc  <= '0;
      r_tx  <= '0;
      r_cyc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_xfer)               r_wc  <= r_wc + WCW'(1);
      if (w_xfer && w_done_tok) r_tx  <= r_tx + TXW'(1);
      if (r_state == RECV)      r_cyc <= r_cyc + 64'd1;
      if (r_state == RECV && w_full && valid) r_ovf <= 1'b1;
    end
  end

  sink_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_xfer),
    .waddr (r_wc[AW-1:0]),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign ready       = w_ready;
  assign done        = (r_state == DONE);
  assign word_count  = r_wc;
  assign cycle_count = r_cyc;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_crd_stream_sink.sv
// Bench for crd_stream_sink: three instances (default, DEPTH=4, TX_NUM=2)
// share one stimulus stream; a per-cycle behavioural model checks every
// instance, and directed literal checks pin the scenario results.
module tb_crd_stream_sink;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, stall;
  logic [16:0] data;
  logic [5:0]  rd_addr;

  logic        ready0, ready1, ready2, done0, done1, done2, ovf0, ovf1, ovf2;
  logic [6:0]  wc0, wc2;
  logic [2:0]  wc1;
  logic [63:0] cyc0, cyc1, cyc2;
  logic [16:0] rdd0, rdd1, rdd2;

  crd_stream_sink u_dut0 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready0), .stall(stall),
    .done(done0), .word_count(wc0), .rd_addr(rd_addr), .rd_data(rdd0),
    .cycle_count(cyc0), .overflow(ovf0));

  crd_stream_sink #(.DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready1), .stall(stall),
    .done(done1), .word_count(wc1), .rd_addr(rd_addr[1:0]), .rd_data(rdd1),
    .cycle_count(cyc1), .overflow(ovf1));

  crd_stream_sink #(.TX_NUM(2)) u_dut2 (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .ready(ready2), .stall(stall),
    .done(done2), .word_count(wc2), .rd_addr(rd_addr), .rd_data(rdd2),
    .cycle_count(cyc2), .overflow(ovf2));

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting for first valid, 1 = receiving, 2 = finished.
  int unsigned     P_DEPTH [3] = '{64, 4, 64};
  int unsigned     P_TX    [3] = '{1, 1, 2};
  int              m_phase [3] = '{0, 0, 0};
  int unsigned     m_wc    [3] = '{0, 0, 0};
  int unsigned     m_tx    [3] = '{0, 0, 0};
  longint unsigned m_cyc   [3] = '{0, 0, 0};
  bit              m_ovf   [3] = '{0, 0, 0};

  function automatic bit m_ready(input int i);
    return !rst && m_phase[i] == 1 && !stall && m_wc[i] < P_DEPTH[i];
  endfunction

  task automatic check_inst(input int i, input logic rdy, input logic dn,
                            input logic [63:0] wc, input logic [63:0] cyc, input logic ov);
    chk($sformatf("ready[%0d]", i),       64'(rdy), 64'(m_ready(i)));
    chk($sformatf("done[%0d]", i),        64'(dn),  64'(m_phase[i] == 2));
    chk($sformatf("word_count[%0d]", i),  wc,       64'(m_wc[i]));
    chk($sformatf("cycle_count[%0d]", i), cyc,      m_cyc[i]);
    chk($sformatf("overflow[%0d]", i),    64'(ov),  64'(m_ovf[i]));
  endtask

  // Compare every instance to the model mid-cycle, then advance the model by one edge.
  bit xf;
  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, ready0, done0, 64'(wc0), cyc0, ovf0);
      check_inst(1, ready1, done1, 64'(wc1), cyc1, ovf1);
      check_inst(2, ready2, done2, 64'(wc2), cyc2, ovf2);
      for (int i = 0; i < 3; i++) begin
        xf = valid && m_ready(i);
        if (rst) begin
          m_phase[i] = 0; m_wc[i] = 0; m_tx[i] = 0; m_cyc[i] = 0; m_ovf[i] = 0;
        end else if (m_phase[i] == 0) begin
          if (valid) m_phase[i] = 1;
        end else if (m_phase[i] == 1) begin
          m_cyc[i]++;
          if (xf) begin
            m_wc[i]++;
            if (data == 17'h10100) begin
              m_tx[i]++;
              if (m_tx[i] == P_TX[i]) m_phase[i] = 2;
            end
          end else if (valid && m_wc[i] == P_DEPTH[i]) begin
            m_ovf[i] = 1;
          end
        end
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1; valid = 1'b0; stall = 1'b0; data = '0; rd_addr = '0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer n words, advancing on handshakes of instance ref_i; optional stall
  // on every even cycle from the third onward.
  task automatic send(input logic [16:0] w [8], input int n, input int ref_i, input bit toggle);
    int idx = 0;
    int c   = 0;
    logic rx;
    while (idx < n && c < 200) begin
      data  = w[idx];
      valid = 1'b1;
      stall = toggle && c >= 2 && (c % 2 == 0);
      @(negedge clk);
      rx = (ref_i == 0) ? ready0 : (ref_i == 1) ? ready1 : ready2;
      @(posedge clk);
      #1;
      if (rx) idx++;
      c++;
    end
    valid = 1'b0;
    stall = 1'b0;
    if (idx < n) chk("send_timeout", 64'(idx), 64'(n));
  endtask

  task automatic readback(input int i, input int a, input logic [16:0] exp);
    rd_addr = 6'(a);
    @(posedge clk);
    #1;
    chk($sformatf("rd_data[%0d][%0d]", i, a),
        64'((i == 0) ? rdd0 : (i == 1) ? rdd1 : rdd2), 64'(exp));
  endtask

  logic [16:0] w [8];

  initial begin
    rst = 1'b1; valid = 1'b0; stall = 1'b0; data = '0; rd_addr = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", 64'(rdd0), 64'd0);
    chk("reset_ready",   64'(ready0), 64'd0);
    chk("reset_wc",      64'(wc0), 64'd0);
    chk("reset_cycles",  cyc0, 64'd0);
    rst = 1'b0;

    // Back-to-back four words, single done token.
    w = '{17'h00001, 17'h00002, 17'h10000, 17'h10100, 17'h0, 17'h0, 17'h0, 17'h0};
    send(w, 4, 0, 1'b0);
    chk("t1_done",   64'(done0), 64'd1);
    chk("t1_wc",     64'(wc0),   64'd4);
    chk("t1_cycles", cyc0,       64'd4);
    for (int a = 0; a < 4; a++) readback(0, a, w[a]);

    // valid held after done: everything frozen, no overflow.
    valid = 1'b1; data = 17'h00009;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_hold_ready", 64'(ready0), 64'd0);
    chk("t1_hold_wc",    64'(wc0),    64'd4);
    chk("t1_hold_cyc",   cyc0,        64'd4);
    chk("t1_hold_ovf",   64'(ovf0),   64'd0);
    valid = 1'b0;

    // Same stream with stall toggling.
    do_reset(1);
    send(w, 4, 0, 1'b1);
    chk("t2_done",   64'(done0), 64'd1);
    chk("t2_wc",     64'(wc0),   64'd4);
    chk("t2_cycles", cyc0,       64'd7);
    for (int a = 0; a < 4; a++) readback(0, a, w[a]);

    // Six plain words into the DEPTH=4 instance.
    do_reset(1);
    w = '{17'h00011, 17'h00012, 17'h00013, 17'h00014, 17'h00015, 17'h00016, 17'h0, 17'h0};
    send(w, 6, 0, 1'b0);
    chk("t3_wc",    64'(wc1),    64'd4);
    chk("t3_ovf",   64'(ovf1),   64'd1);
    chk("t3_ready", 64'(ready1), 64'd0);
    chk("t3_done",  64'(done1),  64'd0);
    for (int a = 0; a < 4; a++) readback(1, a, w[a]);

    // Two done tokens needed by the TX_NUM=2 instance.
    do_reset(1);
    w = '{17'h00005, 17'h10100, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    send(w, 2, 2, 1'b0);
    chk("t4_mid_done", 64'(done2), 64'd0);
    chk("t4_mid_wc",   64'(wc2),   64'd2);
    w = '{17'h00006, 17'h10100, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    send(w, 2, 2, 1'b0);
    chk("t4_done", 64'(done2), 64'd1);
    chk("t4_wc",   64'(wc2),   64'd4);

    // Reset mid-stream with a word offered during rst.
    do_reset(1);
    w = '{17'h00021, 17'h00022, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    send(w, 2, 0, 1'b0);
    rst = 1'b1; valid = 1'b1; data = 17'h00777;
    @(posedge clk);
    #1 rst = 1'b0; valid = 1'b0;
    chk("t5_ready", 64'(ready0), 64'd0);
    chk("t5_wc",    64'(wc0),    64'd0);
    chk("t5_cyc",   cyc0,        64'd0);
    chk("t5_done",  64'(done0),  64'd0);
    w = '{17'h00aaa, 17'h00bbb, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    send(w, 2, 0, 1'b0);
    readback(0, 0, 17'h00aaa);
    readback(0, 1, 17'h00bbb);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
